// File: rtl/bcd_to_bin_serial_pkg.sv
// Shared types and helpers for the serial BCD-to-binary converter.
package bcd_pkg;

  typedef enum logic {IDLE, SHIFT} conv_state_t;

  localparam logic [3:0] BCD_MAX = 4'd9;

  // True when the nibble is a legal decimal digit.
  function automatic logic bcd_digit_valid(input logic [3:0] nibble);
    return (nibble <= BCD_MAX);
  endfunction

endpackage

// File: rtl/bcd_to_bin_serial_if.sv
// Request/response bundle for the serial BCD-to-binary converter.
interface bcd_to_bin_serial_if #(
  parameter int DIGITS = 3,
  parameter int BIN_W  = 10
);
  logic                  start;
  logic [4*DIGITS-1:0]   bcd_in;
  logic                  busy;
  logic                  done;
  logic                  err;
  logic [BIN_W-1:0]      bin_out;

  modport master (
    output start, bcd_in,
    input  busy, done, err, bin_out
  );

  modport slave (
    input  start, bcd_in,
    output busy, done, err, bin_out
  );
endinterface

// File: rtl/bcd_to_bin_serial_nibble_adjust.sv
// Per-digit correction step of reverse double-dabble: a digit that reached
// 8 or more after the right shift took a borrowed 10 from its neighbour,
// which reads as 16/2 = 8; subtracting 3 restores the decimal weight (8-3=5).
module bcd_nibble_adjust (
  input  logic [3:0] i_nibble,
  output logic [3:0] o_nibble
);

  assign o_nibble = (i_nibble >= 4'd8) ? (i_nibble - 4'd3) : i_nibble;

endmodule

// File: rtl/bcd_to_bin_serial.sv
// Iterative BCD-to-binary converter: shifts one bit per clock out of the
// packed BCD word into a binary shift register, correcting each digit after
// every shift. A request containing a non-decimal digit is rejected in one
// cycle with err set.
module bcd_to_bin_serial
  import bcd_pkg::*;
#(
  parameter int DIGITS = 3,
  parameter int BIN_W  = 10
) (
  input  logic                CLOCK_50,
  input  logic                Reset,
  bcd_to_bin_serial_if.slave  bus
);

  localparam int SR_W  = 4 * DIGITS;
  localparam int CNT_W = $clog2(SR_W + 1);
  localparam int EXT_W = (BIN_W > SR_W) ? BIN_W : SR_W;

  conv_state_t        r_state;
  conv_state_t        w_state_nxt;
  logic [CNT_W-1:0]   r_cnt;
  logic [SR_W-1:0]    r_bcd_sr;
  logic [SR_W-1:0]    r_bin_sr;
  logic               r_busy;
  logic               r_done;
  logic               r_err;
  logic [BIN_W-1:0]   r_bin_out;

  logic [SR_W-1:0]    w_bcd_shift;
  logic [SR_W-1:0]    w_bcd_adj;
  logic [SR_W-1:0]    w_bin_shift;
  logic [EXT_W-1:0]   w_bin_ext;
  logic               w_all_valid;
  logic               w_last;
  logic               w_accept;

  // The BCD and binary registers shift as one long word; the LSB of the BCD
  // side drops into the MSB of the binary side.
  assign {w_bcd_shift, w_bin_shift} = {r_bcd_sr, r_bin_sr} >> 1;

  for (genvar g = 0; g < DIGITS; g++) begin : g_adj
    bcd_nibble_adjust u_adj (
      .i_nibble (w_bcd_shift[4*g +: 4]),
      .o_nibble (w_bcd_adj[4*g +: 4])
    );
  end

  assign w_last    = (r_cnt == CNT_W'(SR_W - 1));
  assign w_bin_ext = EXT_W'(w_bin_shift);
  assign w_accept  = (r_state == IDLE) && bus.start && w_all_valid;

  // Flag any nibble of the incoming word that is not a decimal digit.
  always_comb begin
    w_all_valid = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (!bcd_digit_valid(bus.bcd_in[4*i +: 4])) w_all_valid = 1'b0;
    end
  end

  // Next-state logic: leave IDLE on an accepted request, return after the last shift.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_accept) w_state_nxt = SHIFT;
      SHIFT:   if (w_last)   w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge CLOCK_50 or posedge Reset) begin
    if (Reset) r_state <= IDLE;
    else       r_state <= w_state_nxt;
  end

  // Shift registers, counter and registered outputs.
  always_ff @(posedge CLOCK_50 or posedge Reset) begin
    if (Reset) begin
      r_cnt     <= '0;
      r_bcd_sr  <= '0;
      r_bin_sr  <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_err     <= 1'b0;
      r_bin_out <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (bus.start) begin
            if (w_all_valid) begin
              r_bcd_sr <= bus.bcd_in;
              r_bin_sr <= '0;
              r_cnt    <= '0;
              r_busy   <= 1'b1;
              r_err    <= 1'b0;
            end else begin
              r_done    <= 1'b1;
              r_err     <= 1'b1;
              r_bin_out <= '0;
            end
          end
        end
        SHIFT: begin
          r_bcd_sr <= w_bcd_adj;
          r_bin_sr <= w_bin_shift;
          r_cnt    <= r_cnt + CNT_W'(1);
          if (w_last) begin
            r_bin_out <= w_bin_ext[BIN_W-1:0];
            r_done    <= 1'b1;
            r_busy    <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  // The result must fit in BIN_W bits; anything above would be silently lost.
  a_no_overflow: assert property (@(posedge CLOCK_50) disable iff (Reset)
    ((r_state == SHIFT) && w_last) |-> ((w_bin_ext >> BIN_W) == '0));

  assign bus.busy    = r_busy;
  assign bus.done    = r_done;
  assign bus.err     = r_err;
  assign bus.bin_out = r_bin_out;

endmodule
